// File: rtl/x2050_pkg.sv
// Shared definitions for the 2050 IAR/ILC slice: IV microorder encodings and
// IBM bit-numbering helpers (IBM bit 0 is the MSB).
package x2050_pkg;

    localparam logic [2:0] IV_NOP    = 3'd0;
    localparam logic [2:0] IV_LDT    = 3'd1;
    localparam logic [2:0] IV_INC2   = 3'd2;
    localparam logic [2:0] IV_INC4   = 3'd3;
    localparam logic [2:0] IV_INCILC = 3'd4;
    localparam logic [2:0] IV_DECILC = 3'd5;

    function automatic int ibm_idx(input int width, input int ibm_bit);
        return width - 1 - ibm_bit;
    endfunction

    // Vector indices of the IBM bits this slice cares about
    localparam int T_LSB_IDX = ibm_idx(32, 31);
    localparam int OP_B0_IDX = ibm_idx(8, 0);
    localparam int OP_B1_IDX = ibm_idx(8, 1);

endpackage

// File: rtl/x2050iar_ilcdec.sv
// Combinational opcode-to-ILC decoder; the top two IBM opcode bits give the
// instruction length in halfwords.
module x2050ilcdec
    import x2050_pkg::*;
(
    input  logic [7:0] i_op,
    output logic [1:0] o_ilc
);

    logic [1:0] len_sel_s;
    logic       unused_op_s;

    assign len_sel_s   = {i_op[OP_B0_IDX], i_op[OP_B1_IDX]};
    assign unused_op_s = ^i_op[5:0];

    // RR = 1 halfword, RX/RS/SI = 2, SS = 3
    always_comb begin
        o_ilc = 2'd1;
        case (len_sel_s)
            2'b00:   o_ilc = 2'd1;
            2'b01:   o_ilc = 2'd2;
            2'b10:   o_ilc = 2'd2;
            2'b11:   o_ilc = 2'd3;
            default: o_ilc = 2'd1;
        endcase
    end

endmodule

// File: rtl/x2050iar.sv
// Instruction address register and instruction length code, updated on
// ROS-advance cycles under the IV microorder, with sticky odd-address flag.
module x2050iar
    import x2050_pkg::*;
#(
    parameter int               IAR_W     = 24,
    parameter logic [IAR_W-1:0] RESET_IAR = 24'h000000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ros_advance,
    input  logic [2:0]       i_iv,
    input  logic [31:0]      i_t_reg,
    input  logic             i_ilc_load,
    input  logic [7:0]       i_op,
    input  logic             i_clr_chk,
    output logic [IAR_W-1:0] o_iar,
    output logic [1:0]       o_ilc,
    output logic             o_iar_spec,
    output logic             o_iar_wrap
);

    logic [IAR_W-1:0] iar_r, iar_n_s, delta_s;
    logic [IAR_W:0]   add_s, sub_s;
    logic [1:0]       ilc_r, ilc_n_s, ilc_dec_s;
    logic             spec_r, spec_n_s, wrap_r, wrap_n_s;
    logic             unused_t_s;

    assign unused_t_s = ^i_t_reg[31:IAR_W];

    x2050ilcdec u_ilcdec (
        .i_op  (i_op),
        .o_ilc (ilc_dec_s)
    );

    // Next-state: IV arithmetic uses the ILC held before this edge
    always_comb begin
        iar_n_s  = iar_r;
        ilc_n_s  = ilc_r;
        spec_n_s = spec_r;
        wrap_n_s = 1'b0;
        delta_s  = '0;
        case (i_iv)
            IV_INC2:   delta_s = IAR_W'(3'd2);
            IV_INC4:   delta_s = IAR_W'(3'd4);
            IV_INCILC: delta_s = IAR_W'({ilc_r, 1'b0});
            IV_DECILC: delta_s = IAR_W'({ilc_r, 1'b0});
            default:   delta_s = '0;
        endcase
        add_s = {1'b0, iar_r} + {1'b0, delta_s};
        sub_s = {1'b0, iar_r} - {1'b0, delta_s};
        if (i_ros_advance) begin
            case (i_iv)
                IV_LDT: begin
                    iar_n_s = i_t_reg[IAR_W-1:0];
                end
                IV_INC2, IV_INC4, IV_INCILC: begin
                    iar_n_s  = add_s[IAR_W-1:0];
                    wrap_n_s = add_s[IAR_W];
                end
                IV_DECILC: begin
                    iar_n_s  = sub_s[IAR_W-1:0];
                    wrap_n_s = sub_s[IAR_W];
                end
                default: begin
                    iar_n_s = iar_r;
                end
            endcase
            if (i_ilc_load) begin
                ilc_n_s = ilc_dec_s;
            end else begin
                ilc_n_s = ilc_r;
            end
            if ((i_iv == IV_LDT) && i_t_reg[T_LSB_IDX]) begin
                spec_n_s = 1'b1;
            end else if (i_clr_chk) begin
                spec_n_s = 1'b0;
            end else begin
                spec_n_s = spec_r;
            end
        end else begin
            wrap_n_s = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            iar_r  <= RESET_IAR;
            ilc_r  <= 2'd0;
            spec_r <= 1'b0;
            wrap_r <= 1'b0;
        end else begin
            iar_r  <= iar_n_s;
            ilc_r  <= ilc_n_s;
            spec_r <= spec_n_s;
            wrap_r <= wrap_n_s;
        end
    end

    assign o_iar      = iar_r;
    assign o_ilc      = ilc_r;
    assign o_iar_spec = spec_r;
    assign o_iar_wrap = wrap_r;

endmodule

// File: tb/tb_x2050iar.sv
// Directed self-checking bench for x2050iar.
module tb_x2050iar;

    logic        i_clk = 1'b0;
    logic        i_reset, i_ros_advance, i_ilc_load, i_clr_chk;
    logic [2:0]  i_iv;
    logic [31:0] i_t_reg;
    logic [7:0]  i_op;
    logic [23:0] o_iar;
    logic [1:0]  o_ilc;
    logic        o_iar_spec, o_iar_wrap;

    int checks = 0;
    int passes = 0;

    x2050iar dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_ros_advance (i_ros_advance),
        .i_iv          (i_iv),
        .i_t_reg       (i_t_reg),
        .i_ilc_load    (i_ilc_load),
        .i_op          (i_op),
        .i_clr_chk     (i_clr_chk),
        .o_iar         (o_iar),
        .o_ilc         (o_ilc),
        .o_iar_spec    (o_iar_spec),
        .o_iar_wrap    (o_iar_wrap)
    );

    always #5 i_clk = ~i_clk;

    // Apply one cycle of inputs, clock it, and settle 1ns past the edge
    task automatic cyc(input logic rst, input logic adv, input logic [2:0] iv,
                       input logic [31:0] t, input logic ld, input logic [7:0] op,
                       input logic clr);
        i_reset = rst; i_ros_advance = adv; i_iv = iv; i_t_reg = t;
        i_ilc_load = ld; i_op = op; i_clr_chk = clr;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset;
        cyc(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 3'd1, 32'h00123456, 1'b1, 8'hC0, 1'b0);
        checks++;
        if (o_iar !== 24'h123456) $display("FAIL preload iar got %h want 123456", o_iar);
        else passes++;
        cyc(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({o_iar, o_ilc, o_iar_spec, o_iar_wrap} !== {24'h000000, 2'd0, 1'b0, 1'b0})
            $display("FAIL reset got iar=%h ilc=%0d spec=%b wrap=%b want 000000/0/0/0",
                     o_iar, o_ilc, o_iar_spec, o_iar_wrap);
        else passes++;
        // ILC=0: IV=4 and IV=5 leave IAR alone with no wrap
        cyc(1'b0, 1'b1, 3'd4, 32'h0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({o_iar, o_iar_wrap} !== {24'h000000, 1'b0})
            $display("FAIL ilc0_inc got iar=%h wrap=%b want 000000/0", o_iar, o_iar_wrap);
        else passes++;
        cyc(1'b0, 1'b1, 3'd5, 32'h0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({o_iar, o_iar_wrap} !== {24'h000000, 1'b0})
            $display("FAIL ilc0_dec got iar=%h wrap=%b want 000000/0", o_iar, o_iar_wrap);
        else passes++;
    endtask

    task automatic test_load_inc;
        cyc(1'b0, 1'b1, 3'd1, 32'hAB001000, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({o_iar, o_iar_spec} !== {24'h001000, 1'b0})
            $display("FAIL load got iar=%h spec=%b want 001000/0", o_iar, o_iar_spec);
        else passes++;
        cyc(1'b0, 1'b1, 3'd3, 32'h0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (o_iar !== 24'h001004) $display("FAIL inc4 got %h want 001004", o_iar);
        else passes++;
        cyc(1'b0, 1'b0, 3'd3, 32'h0, 1'b1, 8'hC0, 1'b0);
        checks++;
        if ({o_iar, o_ilc} !== {24'h001004, 2'd0})
            $display("FAIL hold got iar=%h ilc=%0d want 001004/0", o_iar, o_ilc);
        else passes++;
        cyc(1'b0, 1'b1, 3'd6, 32'h0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (o_iar !== 24'h001004) $display("FAIL reserved_iv got %h want 001004", o_iar);
        else passes++;
    endtask

    task automatic test_wrap;
        cyc(1'b0, 1'b1, 3'd1, 32'h00FFFFFE, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 3'd2, 32'h0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({o_iar, o_iar_wrap} !== {24'h000000, 1'b1})
            $display("FAIL carry got iar=%h wrap=%b want 000000/1", o_iar, o_iar_wrap);
        else passes++;
        cyc(1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({o_iar, o_iar_wrap} !== {24'h000000, 1'b0})
            $display("FAIL wrap_clear got iar=%h wrap=%b want 000000/0", o_iar, o_iar_wrap);
        else passes++;
        // Load 000002 and ILC=3 together, then back up by 6
        cyc(1'b0, 1'b1, 3'd1, 32'h00000002, 1'b1, 8'hC0, 1'b0);
        checks++;
        if (o_ilc !== 2'd3) $display("FAIL ilc_ss got %0d want 3", o_ilc);
        else passes++;
        cyc(1'b0, 1'b1, 3'd5, 32'h0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({o_iar, o_iar_wrap} !== {24'hFFFFFC, 1'b1})
            $display("FAIL borrow got iar=%h wrap=%b want fffffc/1", o_iar, o_iar_wrap);
        else passes++;
        cyc(1'b0, 1'b0, 3'd2, 32'h0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({o_iar, o_iar_wrap} !== {24'hFFFFFC, 1'b0})
            $display("FAIL noadv_wrap got iar=%h wrap=%b want fffffc/0", o_iar, o_iar_wrap);
        else passes++;
        // Load after a wrap must not report wrap
        cyc(1'b0, 1'b1, 3'd4, 32'h0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 3'd1, 32'h00000010, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({o_iar, o_iar_wrap} !== {24'h000010, 1'b0})
            $display("FAIL load_nowrap got iar=%h wrap=%b want 000010/0", o_iar, o_iar_wrap);
        else passes++;
    endtask

    task automatic test_ilc;
        cyc(1'b0, 1'b1, 3'd1, 32'h00002000, 1'b1, 8'h1A, 1'b0);
        checks++;
        if ({o_iar, o_ilc} !== {24'h002000, 2'd1})
            $display("FAIL ilc_rr got iar=%h ilc=%0d want 002000/1", o_iar, o_ilc);
        else passes++;
        cyc(1'b0, 1'b1, 3'd4, 32'h0, 1'b1, 8'hD2, 1'b0);
        checks++;
        if ({o_iar, o_ilc} !== {24'h002002, 2'd3})
            $display("FAIL old_ilc got iar=%h ilc=%0d want 002002/3", o_iar, o_ilc);
        else passes++;
        cyc(1'b0, 1'b1, 3'd4, 32'h0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({o_iar, o_ilc} !== {24'h002008, 2'd3})
            $display("FAIL new_ilc got iar=%h ilc=%0d want 002008/3", o_iar, o_ilc);
        else passes++;
        cyc(1'b0, 1'b1, 3'd0, 32'h0, 1'b1, 8'h5A, 1'b0);
        checks++;
        if (o_ilc !== 2'd2) $display("FAIL ilc_rx got %0d want 2", o_ilc);
        else passes++;
        cyc(1'b0, 1'b1, 3'd0, 32'h0, 1'b1, 8'h9A, 1'b0);
        checks++;
        if (o_ilc !== 2'd2) $display("FAIL ilc_rs got %0d want 2", o_ilc);
        else passes++;
    endtask

    task automatic test_spec;
        cyc(1'b0, 1'b1, 3'd1, 32'hFF001001, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({o_iar, o_iar_spec} !== {24'h001001, 1'b1})
            $display("FAIL odd_load got iar=%h spec=%b want 001001/1", o_iar, o_iar_spec);
        else passes++;
        cyc(1'b0, 1'b1, 3'd1, 32'h00003003, 1'b0, 8'h00, 1'b1);
        checks++;
        if ({o_iar, o_iar_spec} !== {24'h003003, 1'b1})
            $display("FAIL set_wins got iar=%h spec=%b want 003003/1", o_iar, o_iar_spec);
        else passes++;
        cyc(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (o_iar_spec !== 1'b1) $display("FAIL clr_noadv got %b want 1", o_iar_spec);
        else passes++;
        cyc(1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (o_iar_spec !== 1'b0) $display("FAIL clr got %b want 0", o_iar_spec);
        else passes++;
        // Odd IAR from arithmetic must not set the flag
        cyc(1'b0, 1'b1, 3'd2, 32'h0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({o_iar, o_iar_spec} !== {24'h003005, 1'b0})
            $display("FAIL arith_nospec got iar=%h spec=%b want 003005/0", o_iar, o_iar_spec);
        else passes++;
    endtask

    task automatic test_reset_midseq;
        cyc(1'b0, 1'b1, 3'd1, 32'h00000777, 1'b1, 8'hC0, 1'b0);
        cyc(1'b1, 1'b1, 3'd1, 32'h00345679, 1'b1, 8'hC0, 1'b0);
        checks++;
        if ({o_iar, o_ilc, o_iar_spec, o_iar_wrap} !== {24'h000000, 2'd0, 1'b0, 1'b0})
            $display("FAIL reset_wins got iar=%h ilc=%0d spec=%b wrap=%b want 000000/0/0/0",
                     o_iar, o_ilc, o_iar_spec, o_iar_wrap);
        else passes++;
    endtask

    initial begin
        test_reset;
        test_load_inc;
        test_wrap;
        test_ilc;
        test_spec;
        test_reset_midseq;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/x2050iar.md
Name: x2050iar

Overview:
- Upstream neighbour of the 2050 H register: owns the 24-bit instruction address register (IAR) and the 2-bit instruction length code (ILC).
- Its IAR output drives the H register's IAR input; ILC feeds PSW/interrupt assembly.
- Updated only on ROS-advance cycles under a 3-bit microorder field (IV). Also keeps a sticky odd-address specification flag and flags address wrap.

Parameters:
IAR_W, 24, IAR width in bits; address arithmetic is modulo 2**IAR_W.
RESET_IAR, 24'h000000, IAR value loaded on reset.

Ports:
i_clk  input  1  system clock; all state changes on rising edge.
i_reset  input  1  synchronous, active-high reset.
i_ros_advance  input  1  microword-advance qualifier; no state changes when low, except reset.
i_iv  input  3  IAR microorder, encoded as in Behaviour.
i_t_reg  input  32  T register (IBM bit 0 = index 31); IBM bits 8-31 are the load source.
i_ilc_load  input  1  load ILC from i_op this cycle.
i_op  input  8  opcode byte; IBM bits 0-1 select the instruction length.
i_clr_chk  input  1  clear sticky spec flag.
o_iar  output  IAR_W  current IAR.
o_ilc  output  2  current ILC (0 = none, 1/2/3 halfwords).
o_iar_spec  output  1  sticky: an odd address was loaded.
o_iar_wrap  output  1  one-cycle pulse: last update carried or borrowed out of IAR.

Behaviour:
- Reset (synchronous, dominates everything): o_iar=RESET_IAR, o_ilc=0, o_iar_spec=0, o_iar_wrap=0. A reset in the middle of any sequence discards that cycle's microorders.
- When i_ros_advance=0: all registers hold, and o_iar_wrap is forced to 0 on that edge.
- IV encoding, applied when i_ros_advance=1:
  - 0: nop.
  - 1: IAR <= T[8:31].
  - 2: IAR += 2.
  - 3: IAR += 4.
  - 4: IAR += 2*ILC.
  - 5: IAR -= 2*ILC (backup for retry/EX).
  - 6, 7: reserved, treated as nop.
- Arithmetic is unsigned, IAR_W bits, modulo 2**IAR_W.
  - o_iar_wrap=1 for the following cycle when an add carries out (e.g. FFFFFE+2 -> 000000), or a subtract borrows (e.g. 000002-6 -> FFFFFC).
  - o_iar_wrap is 0 after every other update, including loads.
- IV=4 or 5 with ILC=0 leaves IAR unchanged and gives no wrap.
- ILC load (i_ilc_load=1 with advance): ILC <= 1 if op[0:1]=00, 2 if 01 or 10, 3 if 11. Otherwise ILC holds.
- Same-cycle IV=4/5 and ILC load: the IAR arithmetic uses the OLD ILC; the new ILC is visible next cycle.
- Spec flag:
  - Set when IV=1 loads an address whose IBM bit 31 (LSB) = 1. The odd value is still loaded.
  - i_clr_chk (with advance) clears it.
  - Set and clear in the same cycle: set wins.
  - The flag is never set by arithmetic.
- All outputs are registered; latency is exactly one clock from an advance edge to the visible value.

Decomposition:
- Shared package x2050_pkg: IV encodings (IV_NOP, IV_LDT, IV_INC2, IV_INC4, IV_INCILC, IV_DECILC) and the IBM-bit index helper constant.
- One natural sub-module, x2050ilcdec: combinational opcode-to-ILC decoder, reused by the interrupt/PSW logic.
- The rest lives in one flat sequential block.

Test Plan:
- Reset with IAR previously 123456 -> o_iar=000000, o_ilc=0, o_iar_spec=0, o_iar_wrap=0 on the next clock.
- T=32'hXX001000, IV=1, advance -> o_iar=001000. Then IV=3 -> 001004. Repeat IV=3 with advance=0 -> stays 001004.
- IAR=FFFFFE, IV=2 -> o_iar=000000, o_iar_wrap=1 for one cycle. Next nop -> wrap=0. IAR=000002, ILC=3, IV=5 -> FFFFFC, wrap=1.
- ILC=1, then same cycle i_op=8'hD2 with i_ilc_load and IV=4 from 002000 -> o_iar=002002, o_ilc=3. Next IV=4 -> 002008.
- T low bits 001001, IV=1 -> o_iar=001001, o_iar_spec=1. IV=1 plus i_clr_chk same cycle with odd T -> spec stays 1. i_clr_chk alone -> 0.
- i_reset asserted in the same cycle as IV=1 and i_ilc_load -> reset values, load ignored.
